sysid_regs: RTL and testbench

- Parametrised system-identification and uptime register block; successor to the two-word sysid slave.
- Sits on the Avalon-MM control bus as a fixed-latency, pipelined read/write slave.
- Returns the system ID, the build timestamp and NUM_USER_WORDS constant user words.
- Adds a free-running uptime counter with a coherent 64-bit snapshot, preload, clear, freeze and a sticky wrap flag, plus a scratch register for bus sanity checks.

---
 rtl/sysid_regs_if.sv | 21 ++
 rtl/sysid_regs.sv | 135 +++++++++++++
 tb/tb_sysid_regs.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sysid_regs_if.sv
// Control-bus bundle for the sysid_regs slave: word-addressed reads and writes,
// fixed-latency read return, and a wait signal that this slave never raises.
interface sysid_regs_if;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sysid_regs.sv
// System-identification and uptime register block.
// Returns ID, build timestamp, info and user constants. Also provides a
// free-running uptime counter with a coherent LO/HI snapshot, preload, clear,
// freeze and a sticky wrap flag, plus a scratch register. Reads return after a
// fixed READ_LATENCY and can be issued every cycle.
module sysid_regs #(
    parameter logic [31:0]  SYSTEM_ID      = 32'h0000_0000,
    parameter logic [31:0]  TIMESTAMP      = 32'd1394485293,
    parameter int           NUM_USER_WORDS = 4,
    parameter logic [255:0] USER_WORDS     = 256'h0,
    parameter int           READ_LATENCY   = 1,
    parameter int           UPTIME_WIDTH   = 64
) (
    input  logic        clock,
    input  logic        reset,
    sysid_regs_if.slave bus
);

    localparam logic [UPTIME_WIDTH-1:0] UPTIME_MAX = '1;
    localparam logic [31:0] INFO_WORD =
        {16'h0, 4'(READ_LATENCY), 4'b0, 8'(NUM_USER_WORDS)};

    logic [UPTIME_WIDTH-1:0] uptime_reg;
    logic [31:0]             shadow_hi_reg;
    logic [31:0]             preload_hi_reg;
    logic [31:0]             scratch_reg;
    logic                    freeze_reg;
    logic                    wrap_reg;

    logic [READ_LATENCY-1:0] valid_pipe_reg;
    logic [31:0]             data_pipe_reg [READ_LATENCY];

    logic [63:0] uptime_ext;
    logic [31:0] read_mux;
    logic        user_hit;
    logic        wr_lo, wr_hi, wr_scratch, wr_ctrl, rd_lo;

    // Upper bits beyond UPTIME_WIDTH read as zero.
    assign uptime_ext = 64'(uptime_reg);

    assign wr_lo      = bus.write && (bus.address == 4'd2);
    assign wr_hi      = bus.write && (bus.address == 4'd3);
    assign wr_scratch = bus.write && (bus.address == 4'd4);
    assign wr_ctrl    = bus.write && (bus.address == 4'd5);
    assign rd_lo      = bus.read  && (bus.address == 4'd2);

    assign user_hit = bus.address[3] &&
                      ({29'b0, bus.address[2:0]} < 32'(NUM_USER_WORDS));

    // Read data selected from pre-write register state in the accept cycle.
    always_comb begin
        read_mux = '0;
        case (bus.address)
            4'd0:    read_mux = SYSTEM_ID;
            4'd1:    read_mux = TIMESTAMP;
            4'd2:    read_mux = uptime_ext[31:0];
            4'd3:    read_mux = shadow_hi_reg;
            4'd4:    read_mux = scratch_reg;
            4'd5:    read_mux = {29'b0, wrap_reg, freeze_reg, 1'b0};
            4'd6:    read_mux = INFO_WORD;
            default: begin
                if (user_hit) begin
                    read_mux = USER_WORDS[{bus.address[2:0], 5'd0} +: 32];
                end
            end
        endcase
    end

    // Uptime counter (clear > load > increment) and writable registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_reg     <= '0;
            shadow_hi_reg  <= '0;
            preload_hi_reg <= '0;
            scratch_reg    <= '0;
            freeze_reg     <= 1'b0;
            wrap_reg       <= 1'b0;
        end else begin
            if (wr_ctrl && bus.writedata[0]) begin
                uptime_reg <= '0;
                wrap_reg   <= 1'b0;
            end else if (wr_lo) begin
                uptime_reg <= UPTIME_WIDTH'({preload_hi_reg, bus.writedata});
                wrap_reg   <= 1'b0;
            end else if (!freeze_reg) begin
                if (uptime_reg == UPTIME_MAX) begin
                    uptime_reg <= '0;
                    wrap_reg   <= 1'b1;
                end else begin
                    uptime_reg <= uptime_reg + 1'b1;
                end
            end
            if (wr_ctrl) begin
                freeze_reg <= bus.writedata[1];
            end
            if (wr_hi) begin
                preload_hi_reg <= bus.writedata;
            end
            if (wr_scratch) begin
                scratch_reg <= bus.writedata;
            end
            // Snapshot the high half from the same value the LO read returns.
            if (rd_lo) begin
                shadow_hi_reg <= uptime_ext[63:32];
            end
        end
    end

    // Read return pipeline; data stages only move with a valid, so the last
    // stage holds the most recent returned word between pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_pipe_reg <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_pipe_reg[i] <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= bus.read;
            if (bus.read) begin
                data_pipe_reg[0] <= read_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                if (valid_pipe_reg[i-1]) begin
                    data_pipe_reg[i] <= data_pipe_reg[i-1];
                end
            end
        end
    end

    assign bus.readdatavalid = valid_pipe_reg[READ_LATENCY-1];
    assign bus.readdata      = data_pipe_reg[READ_LATENCY-1];
    assign bus.waitrequest   = 1'b0;

endmodule

// File: tb/tb_sysid_regs.sv
// Directed testbench for sysid_regs with READ_LATENCY=2 and two user words.
module tb_sysid_regs;

    localparam int RL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sysid_regs_if bus ();

    sysid_regs #(
        .SYSTEM_ID      (32'h0000_0000),
        .TIMESTAMP      (32'd1394485293),
        .NUM_USER_WORDS (2),
        .USER_WORDS     ({192'h0, 32'h0000_0022, 32'h0000_0011}),
        .READ_LATENCY   (RL),
        .UPTIME_WIDTH   (64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    logic [3:0]  burst_addr [8];
    logic [31:0] burst_exp  [8];

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One bus cycle; for a read, check no early valid, then valid and data
    // exactly RL cycles after the accept edge.
    task automatic xfer(input logic [3:0] addr, input logic do_wr,
                        input logic [31:0] wdata, input logic do_rd,
                        input logic [31:0] exp, input string tag);
        bus.address   = addr;
        bus.write     = do_wr;
        bus.writedata = wdata;
        bus.read      = do_rd;
        @(posedge clock);
        #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        if (do_rd) begin
            for (int i = 1; i < RL; i++) begin
                check_val({tag, " early"}, 64'(bus.readdatavalid), 64'd0);
                @(posedge clock);
                #1;
            end
            check_val({tag, " valid"}, 64'(bus.readdatavalid), 64'd1);
            check_val(tag, 64'(bus.readdata), 64'(exp));
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wdata);
        xfer(addr, 1'b1, wdata, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp,
                      input string tag);
        xfer(addr, 1'b0, 32'h0, 1'b1, exp, tag);
    endtask

    // Back-to-back reads from burst_addr; results must return in order.
    task automatic read_burst(input int n, input string tag);
        for (int c = 0; c < n + RL; c++) begin
            bus.read    = (c < n);
            bus.address = (c < n) ? burst_addr[c] : 4'd0;
            @(posedge clock);
            #1;
            bus.read = 1'b0;
            if ((c - (RL - 1)) >= 0 && (c - (RL - 1)) < n) begin
                check_val($sformatf("%s[%0d] valid", tag, c - (RL - 1)),
                          64'(bus.readdatavalid), 64'd1);
                check_val($sformatf("%s[%0d] data", tag, c - (RL - 1)),
                          64'(bus.readdata), 64'(burst_exp[c - (RL - 1)]));
            end else begin
                check_val($sformatf("%s idle %0d", tag, c),
                          64'(bus.readdatavalid), 64'd0);
            end
        end
    endtask

    initial begin
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;

        // Reset state
        idle(3);
        check_val("reset rdv", 64'(bus.readdatavalid), 64'd0);
        check_val("reset rdata", 64'(bus.readdata), 64'd0);
        check_val("waitrequest", 64'(bus.waitrequest), 64'd0);
        reset = 1'b0;

        // Constant words, back to back
        burst_addr[0] = 4'd0; burst_exp[0] = 32'h0000_0000;
        burst_addr[1] = 4'd1; burst_exp[1] = 32'h531E_282D;
        burst_addr[2] = 4'd6; burst_exp[2] = 32'h0000_2002;
        burst_addr[3] = 4'd7; burst_exp[3] = 32'h0000_0000;
        read_burst(4, "const");

        // Scratch, including read and write in the same cycle
        wr(4'd4, 32'hDEAD_BEEF);
        rd(4'd4, 32'hDEAD_BEEF, "scratch");
        xfer(4'd4, 1'b1, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF, "scratch rw");
        rd(4'd4, 32'h0000_0001, "scratch after rw");

        // Preload past a carry; LO/HI coherence across a long gap
        wr(4'd3, 32'h0000_0000);
        wr(4'd2, 32'hFFFF_FFFE);
        idle(3);
        rd(4'd2, 32'h0000_0001, "uptime lo carry");
        idle(10);
        rd(4'd3, 32'h0000_0001, "uptime hi shadow");
        rd(4'd5, 32'h0000_0000, "ctrl no wrap");

        // Full 64-bit wrap and sticky flag
        wr(4'd3, 32'hFFFF_FFFF);
        wr(4'd2, 32'hFFFF_FFFF);
        idle(2);
        rd(4'd5, 32'h0000_0004, "ctrl wrap");
        rd(4'd2, 32'h0000_0003, "uptime after wrap");
        rd(4'd3, 32'h0000_0000, "hi after wrap");

        // Clear restarts from 0 and drops wrap
        wr(4'd5, 32'h0000_0001);
        rd(4'd2, 32'h0000_0000, "uptime cleared");
        rd(4'd5, 32'h0000_0000, "ctrl cleared");
        rd(4'd3, 32'h0000_0000, "hi cleared");

        // Freeze holds the count; release resumes it
        wr(4'd5, 32'h0000_0002);
        rd(4'd2, 32'h0000_0007, "frozen a");
        rd(4'd5, 32'h0000_0002, "ctrl freeze");
        idle(5);
        rd(4'd2, 32'h0000_0007, "frozen b");
        wr(4'd5, 32'h0000_0000);
        idle(3);
        rd(4'd2, 32'h0000_000A, "unfrozen");

        // User words and unmapped addresses
        burst_addr[0] = 4'd8;  burst_exp[0] = 32'h0000_0011;
        burst_addr[1] = 4'd9;  burst_exp[1] = 32'h0000_0022;
        burst_addr[2] = 4'd10; burst_exp[2] = 32'h0000_0000;
        burst_addr[3] = 4'd15; burst_exp[3] = 32'h0000_0000;
        read_burst(4, "user");

        // Reset with reads in flight: no valid pulse may come out
        bus.address = 4'd4;
        bus.read    = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("flush rdv %0d", i), 64'(bus.readdatavalid), 64'd0);
            @(posedge clock);
            #1;
        end
        check_val("flush rdata", 64'(bus.readdata), 64'd0);
        reset = 1'b0;
        rd(4'd4, 32'h0000_0000, "scratch after reset");
        rd(4'd5, 32'h0000_0000, "ctrl after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
